// File: rtl/core_pkg.sv
//------------------------------------------------------------------------------
// core_pkg : shared state encoding and default widths for the 16-bit core
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package core_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    localparam int unsigned ROM_AWIDTH_DEF = 8;
    localparam int unsigned RAM_AWIDTH_DEF = 8;
    localparam int unsigned RAM_DWIDTH_DEF = 16;

    // Wide enough for the full legal boot-hold range of 1..255 cycles
    localparam int unsigned BOOT_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/boot_timer.sv
//------------------------------------------------------------------------------
// boot_timer : loadable down-counter, o_done while enabled and expired
// Rev 1.0    : initial release
//------------------------------------------------------------------------------
`default_nettype none

module boot_timer
    import core_pkg::*;
#(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_done
);

    logic [BOOT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= BOOT_CNT_W'(CYCLES - 1);
        end else if (i_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - BOOT_CNT_W'(1);
        end
    end

    assign o_done = i_en && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// pc_sequencer : PC ownership, boot/clear sequencing, redirect and stall control
// Rev 1.0      : initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
    import core_pkg::*;
#(
    parameter int unsigned           ROM_AWIDTH = ROM_AWIDTH_DEF,
    parameter logic [ROM_AWIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           CLR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_stall,
    input  logic                  i_jump,
    input  logic [ROM_AWIDTH-1:0] i_jump_target,
    input  logic                  i_beq_taken,
    input  logic [ROM_AWIDTH-1:0] i_beq_target,
    input  logic                  i_halt,
    output logic                  o_rom_rd,
    output logic [ROM_AWIDTH-1:0] o_rom_raddr,
    output logic                  o_instr_valid,
    output logic [ROM_AWIDTH-1:0] o_pc,
    output logic                  o_flush,
    output logic                  o_regfile_clear,
    output logic                  o_ram_rst,
    output logic                  o_control_rst,
    output logic                  o_running
);

    seq_state_t            state_q;
    logic [ROM_AWIDTH-1:0] pc_q;
    logic [ROM_AWIDTH-1:0] opc_q;
    logic                  valid_q;

    logic                  is_run;
    logic                  is_boot;
    logic                  boot_done;
    logic                  redirect;
    logic                  take_redir;
    logic                  take_fetch;
    logic [ROM_AWIDTH-1:0] redir_target;

    assign is_run       = (state_q == ST_RUN);
    assign is_boot      = (state_q == ST_BOOT);
    assign redirect     = i_jump | i_beq_taken;
    assign redir_target = i_jump ? i_jump_target : i_beq_target;
    assign take_redir   = is_run & ~i_halt & redirect;
    assign take_fetch   = is_run & ~i_halt & ~redirect & ~i_stall;

    boot_timer #(
        .CYCLES (CLR_CYCLES)
    ) u_boot_timer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (is_boot),
        .o_done (boot_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            opc_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    valid_q <= 1'b0;
                    if (boot_done) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_halt) begin
                        state_q <= ST_HALT;
                        valid_q <= 1'b0;
                    end else if (redirect) begin
                        // The read at the old PC still goes out but is marked dead
                        pc_q    <= redir_target;
                        opc_q   <= pc_q;
                        valid_q <= 1'b0;
                    end else if (!i_stall) begin
                        pc_q    <= pc_q + ROM_AWIDTH'(1);
                        opc_q   <= pc_q;
                        valid_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_rom_rd        = take_fetch | take_redir;
    assign o_rom_raddr     = pc_q;
    assign o_instr_valid   = valid_q;
    assign o_pc            = opc_q;
    assign o_flush         = take_redir;
    assign o_regfile_clear = is_boot;
    assign o_ram_rst       = is_boot;
    assign o_control_rst   = is_boot;
    assign o_running       = is_run;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// tb_pc_sequencer : directed + random stimulus against a cycle-level fetch model
// Rev 1.0         : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

    localparam int CLR       = 4;
    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0, jump = 1'b0, beq = 1'b0, halt = 1'b0;
    logic [7:0] jt = '0, bt = '0;

    logic       rd, valid, flush, rfclr, ramrst, ctlrst, running;
    logic [7:0] raddr, pc;
    logic       w_rd, w_valid, w_flush, w_rfclr, w_ramrst, w_ctlrst, w_running;
    logic [7:0] w_raddr, w_pc;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode, remaining boot cycles, fetch address, presented instr
    bit m_known = 1'b0;
    int m_mode, m_left, m_pc, m_opc;
    bit m_valid;

    always #5 clk = ~clk;

    pc_sequencer #(.ROM_AWIDTH(8), .RESET_PC(8'h00), .CLR_CYCLES(CLR)) dut (
        .clk(clk), .rst(rst), .i_stall(stall), .i_jump(jump), .i_jump_target(jt),
        .i_beq_taken(beq), .i_beq_target(bt), .i_halt(halt),
        .o_rom_rd(rd), .o_rom_raddr(raddr), .o_instr_valid(valid), .o_pc(pc),
        .o_flush(flush), .o_regfile_clear(rfclr), .o_ram_rst(ramrst),
        .o_control_rst(ctlrst), .o_running(running)
    );

    pc_sequencer #(.ROM_AWIDTH(8), .RESET_PC(8'hFD), .CLR_CYCLES(CLR)) dut_w (
        .clk(clk), .rst(rst), .i_stall(stall), .i_jump(jump), .i_jump_target(jt),
        .i_beq_taken(beq), .i_beq_target(bt), .i_halt(halt),
        .o_rom_rd(w_rd), .o_rom_raddr(w_raddr), .o_instr_valid(w_valid), .o_pc(w_pc),
        .o_flush(w_flush), .o_regfile_clear(w_rfclr), .o_ram_rst(w_ramrst),
        .o_control_rst(w_ctlrst), .o_running(w_running)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_compare();
        bit run, redir;
        run   = (m_mode == MODE_RUN);
        redir = jump | beq;
        chk("m_rom_rd",  32'(rd),      32'(run && !halt && (redir || !stall)));
        chk("m_flush",   32'(flush),   32'(run && !halt && redir));
        chk("m_clear",   32'({rfclr, ramrst, ctlrst}), (m_mode == MODE_BOOT) ? 32'd7 : 32'd0);
        chk("m_running", 32'(running), 32'(run));
        chk("m_raddr",   32'(raddr),   32'(m_pc));
        chk("m_valid",   32'(valid),   32'(m_valid));
        chk("m_pc",      32'(pc),      32'(m_opc));
    endtask

    task automatic model_update();
        if (rst) begin
            m_known = 1'b1;
            m_mode  = MODE_BOOT;
            m_left  = CLR;
            m_pc    = 0;
            m_opc   = 0;
            m_valid = 1'b0;
        end else if (m_mode == MODE_BOOT) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = MODE_RUN;
        end else if (m_mode == MODE_RUN) begin
            if (halt) begin
                m_mode  = MODE_HALT;
                m_valid = 1'b0;
            end else if (jump || beq) begin
                m_opc   = m_pc;
                m_valid = 1'b0;
                m_pc    = jump ? int'(jt) : int'(bt);
            end else if (!stall) begin
                m_opc   = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 1) % 256;
            end
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic j, input logic [7:0] jtv,
                         input logic b, input logic [7:0] btv, input logic h);
        @(negedge clk);
        rst = r; stall = s; jump = j; jt = jtv; beq = b; bt = btv; halt = h;
        #1;
        if (m_known) model_compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic idle_cycle();
        apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
        tick();
    endtask

    initial begin
        // Boot: two reset cycles, then four clear cycles
        apply(1, 0, 0, 8'h00, 0, 8'h00, 0); tick();
        apply(1, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc",    32'(pc),    32'd0);
        tick();
        for (int i = 0; i < CLR; i++) begin
            apply(0, 1, 1, 8'h55, 1, 8'h66, 1);
            chk("boot_clear", 32'({rfclr, ramrst, ctlrst}), 32'd7);
            chk("boot_rd",    32'(rd), 32'd0);
            tick();
        end
        // First fetches; the FD-reset instance must wrap through FF to 00
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
            chk("fetch_raddr", 32'(raddr), 32'(i));
            chk("wrap_raddr",  32'(w_raddr), 32'(8'(8'hFD + i)));
            chk("wrap_rd",     32'(w_rd), 32'd1);
            if (i > 0) begin
                chk("wrap_pc",    32'(w_pc), 32'(8'(8'hFC + i)));
                chk("wrap_valid", 32'(w_valid), 32'd1);
            end
            tick();
        end
        // Jump and branch together with stall at PC=5: jump wins
        apply(0, 1, 1, 8'h40, 1, 8'h20, 0);
        chk("redir_flush", 32'(flush), 32'd1);
        chk("redir_raddr", 32'(raddr), 32'd5);
        tick();
        apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("redir_kill",  32'(valid), 32'd0);
        chk("redir_fetch", 32'(raddr), 32'h40);
        tick();
        apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("redir_valid", 32'(valid), 32'd1);
        chk("redir_pc",    32'(pc),    32'h40);
        tick();
        // Stall at PC=10 for three cycles
        apply(0, 0, 0, 8'h08, 1, 8'h08, 0); tick();
        idle_cycle(); idle_cycle();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 8'h00, 0, 8'h00, 0);
            chk("stall_rd",    32'(rd),    32'd0);
            chk("stall_raddr", 32'(raddr), 32'h0A);
            chk("stall_pc",    32'(pc),    32'h09);
            chk("stall_valid", 32'(valid), 32'd1);
            tick();
        end
        apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("resume_raddr", 32'(raddr), 32'h0A);
        tick();
        apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("resume_pc", 32'(pc), 32'h0A);
        tick();
        // Halt at PC=7, redirects ignored afterwards, then reset
        apply(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 1'b0); tick();
        idle_cycle(); idle_cycle();
        apply(0, 0, 0, 8'h00, 0, 8'h00, 1);
        chk("halt_rd", 32'(rd), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 8'h33, 1, 8'h44, 0);
            chk("halt_running", 32'(running), 32'd0);
            chk("halt_raddr",   32'(raddr),   32'h07);
            chk("halt_flush",   32'(flush),   32'd0);
            tick();
        end
        apply(1, 0, 0, 8'h00, 0, 8'h00, 0); tick();
        for (int i = 0; i < CLR; i++) idle_cycle();
        apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("reboot_raddr", 32'(raddr), 32'd0);
        chk("reboot_rd",    32'(rd),    32'd1);
        tick();
        // Reset in the same cycle as a jump
        idle_cycle();
        apply(1, 0, 1, 8'h77, 0, 8'h00, 0); tick();
        apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("rstjmp_raddr", 32'(raddr), 32'd0);
        chk("rstjmp_flush", 32'(flush), 32'd0);
        chk("rstjmp_clear", 32'(rfclr), 32'd1);
        tick();
        for (int i = 0; i < CLR + 3; i++) begin
            apply(0, 0, 0, 8'h00, 0, 8'h00, 0);
            chk("rstjmp_nofetch", 32'(raddr == 8'h77), 32'd0);
            tick();
        end
        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            apply(($urandom_range(99) < 2), ($urandom_range(99) < 30),
                  ($urandom_range(99) < 10), 8'($urandom),
                  ($urandom_range(99) < 10), 8'($urandom),
                  ($urandom_range(99) < 2));
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch from the synchronous instruction ROM for the 16-bit MIPS-style core.
- Generates the boot/clear sequence for the register file, data RAM and control unit.
- Applies jump/branch redirects with a one-slot flush and honours pipeline stalls.
- Sits between the external reset, the ROM and the control/decode stage in the top level.

Parameters:
- ROM_AWIDTH, 8: width of the PC and the ROM address.
- RESET_PC, 0: first fetch address after boot.
- CLR_CYCLES, 4: number of cycles the clear/reset outputs are held during boot. Legal range is 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_stall  input  1  freeze request from decode/hazard logic.
- i_jump  input  1  unconditional redirect request.
- i_jump_target  input  ROM_AWIDTH  jump destination.
- i_beq_taken  input  1  taken-branch redirect request.
- i_beq_target  input  ROM_AWIDTH  branch destination.
- i_halt  input  1  stop fetching; the block stays halted until rst.
- o_rom_rd  output  1  ROM read strobe.
- o_rom_raddr  output  ROM_AWIDTH  ROM read address; always equals PC.
- o_instr_valid  output  1  ROM data this cycle is a live instruction.
- o_pc  output  ROM_AWIDTH  address of the instruction qualified by o_instr_valid; used for save-PC.
- o_flush  output  1  redirect accepted; decode must discard its current instruction.
- o_regfile_clear  output  1  register-file clear.
- o_ram_rst  output  1  data-RAM reset.
- o_control_rst  output  1  control-unit reset.
- o_running  output  1  block is in RUN state.

Behaviour:
- States: BOOT, RUN, HALT. A 2-bit encoding is held in the package.
- Reset (rst=1 at an edge, from any state, including mid-fetch or mid-redirect):
  - Next state is BOOT; boot counter loads CLR_CYCLES-1; PC loads RESET_PC.
  - Outputs after that edge: o_instr_valid=0, o_flush=0, o_rom_rd=0, o_running=0, o_pc=RESET_PC.
  - o_regfile_clear, o_ram_rst and o_control_rst are all 1.
- BOOT:
  - The three clear outputs stay 1 and o_rom_rd stays 0.
  - The counter decrements each cycle. At count 0 the next state is RUN, and the clear outputs drop on that same edge.
  - The clear outputs are therefore high for exactly CLR_CYCLES cycles after reset is released.
  - i_stall, i_jump, i_beq_taken and i_halt are ignored in BOOT.
- RUN: evaluate each cycle in this priority order.
  1. i_halt: next state is HALT; o_rom_rd=0 this cycle; PC is held.
  2. Redirect (i_jump or i_beq_taken):
     - i_jump beats i_beq_taken when both are high.
     - The ROM read at the current PC is still issued but is killed: o_instr_valid=0 in the next cycle.
     - o_flush=1 in the current cycle.
     - PC loads the target; the target is fetched in the next cycle; its data is valid two cycles after the redirect.
     - A redirect overrides i_stall in the same cycle.
  3. i_stall:
     - o_rom_rd=0 and PC is held.
     - o_instr_valid and o_pc are held at their current values, so the instruction stays presented.
  4. Otherwise:
     - o_rom_rd=1; PC <= PC+1 modulo 2^ROM_AWIDTH, so 2^AW-1 wraps to 0 with no flag.
     - Next cycle o_instr_valid=1 and o_pc equals the fetched address.
- ROM latency is fixed at 1 cycle. o_instr_valid and o_pc are registered and align with the ROM o_rdata.
- A redirect in the cycle right after another redirect is legal: the second one wins and the first target's fetch is killed.
- A redirect whose target equals the current PC is legal: the address is refetched.
- HALT:
  - o_rom_rd=0, o_instr_valid=0, o_running=0. The halt takes effect on the edge where i_halt is sampled.
  - PC is frozen; all inputs except rst are ignored.
- o_rom_raddr is driven straight from the PC register, with no combinational path from the inputs.
- o_flush is combinational from i_jump/i_beq_taken, qualified by state==RUN.

Decomposition:
- Shared package core_pkg:
  - State encoding constants ST_BOOT=2'd0, ST_RUN=2'd1, ST_HALT=2'd2.
  - Default widths ROM_AWIDTH=8, RAM_AWIDTH=8, RAM_DWIDTH=16.
- One sub-module is natural: boot_timer, a down-counter of CLR_CYCLES with a done pulse, reused for future reset-domain sequencing.
- Redirect priority and PC update stay inline.

Test Plan:
- Boot: rst high 2 cycles, then low, CLR_CYCLES=4 -> clear outputs high for exactly 4 cycles after release; first o_rom_rd=1 with o_rom_raddr=0 on the following cycle; o_instr_valid=1, o_pc=0 one cycle later.
- Linear fetch and wrap: run from RESET_PC=8'hFD -> addresses FD, FE, FF, 00, 01 on consecutive cycles; o_pc trails by one cycle; o_instr_valid stays high throughout.
- Redirect with conflict: at PC=5, pulse i_jump (target 8'h40) and i_beq_taken (target 8'h20) together with i_stall=1 -> o_flush=1; next-cycle o_instr_valid=0; following fetch at 8'h40; valid data with o_pc=8'h40 two cycles after the pulse.
- Stall: i_stall high 3 cycles at PC=10 -> o_rom_rd=0 for 3 cycles; PC, o_pc and o_instr_valid held; fetch resumes at 10 with no address skipped or duplicated.
- Halt then reset: i_halt at PC=7 -> o_rom_rd=0, o_running=0 from the next cycle, and jump pulses have no effect. rst 1 cycle -> BOOT with clears high for 4 cycles, then fetch restarts at 0.
- Reset mid-redirect: rst asserted in the same cycle as i_jump -> PC=RESET_PC, o_flush=0 after the edge, BOOT entered, jump target never fetched.
